// File: rtl/cpu_defs.sv
// Shared front-end definitions: reset PC, fetch FSM states, address/instruction types.
package cpu_defs;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISCARD
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch producer: owns the fetch PC, issues one fetch at a time on the
// SRAM-like instruction bus and writes returned instructions into the instruction FIFO.
// Build option: define FETCH_DUAL_EN for 64-bit aligned fetches that can write two
// instructions per response; without it every fetch yields a single instruction.
module inst_fetch_ctrl
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  addr_t       redirect_pc,
    input  logic        fifo_full,
    output logic        inst_req,
    output addr_t       inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [63:0] inst_rdata,
    output logic        write_en1,
    output logic        write_en2,
    output addr_t       write_address1,
    output addr_t       write_address2,
    output inst_t       write_data1,
    output inst_t       write_data2,
    output logic        fifo_rst
);

    fetch_state_e state, state_n;
    addr_t        pc;
    addr_t        req_pc;
    addr_t        addr_r;
    logic         kill, kill_n;
    logic         issue, accept, resp;

    // Bus address for a given fetch PC
    function automatic addr_t fetch_addr(input addr_t p);
`ifdef FETCH_DUAL_EN
        return {p[31:3], 3'b000};
`else
        return p;
`endif
    endfunction

    // PC following a completed fetch (wraps modulo 2^32)
    function automatic addr_t fetch_next(input addr_t p);
`ifdef FETCH_DUAL_EN
        return {p[31:3] + 29'd1, 3'b000};
`else
        return p + 32'd4;
`endif
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            kill  <= 1'b0;
        end else begin
            state <= state_n;
            kill  <= kill_n;
        end
    end

    // Next-state logic; kill remembers a redirect seen while a request was stalled
    always_comb begin
        state_n = state;
        kill_n  = kill;
        issue   = 1'b0;
        accept  = 1'b0;
        resp    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!redirect_valid && !fifo_full && !write_en1 && !fifo_rst) begin
                    state_n = S_REQ;
                    issue   = 1'b1;
                end
            end
            S_REQ: begin
                if (inst_addr_ok) begin
                    accept  = 1'b1;
                    kill_n  = 1'b0;
                    state_n = (redirect_valid || kill) ? S_DISCARD : S_WAIT;
                end else if (redirect_valid) begin
                    kill_n = 1'b1;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    state_n = S_IDLE;
                    resp    = !redirect_valid;
                end else if (redirect_valid) begin
                    state_n = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (inst_data_ok) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Fetch PC: redirect wins over sequential advance
    always_ff @(posedge clk) begin
        if (rst)                 pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_pc;
        else if (resp)           pc <= fetch_next(req_pc);
    end

    // Request address is captured at issue so a redirect cannot disturb a stalled request
    always_ff @(posedge clk) begin
        if (issue)  addr_r <= fetch_addr(pc);
        if (accept) req_pc <= pc;
    end

    // One-cycle FIFO pointer reset following a redirect
    always_ff @(posedge clk) begin
        if (rst) fifo_rst <= 1'b0;
        else     fifo_rst <= redirect_valid;
    end

    assign inst_req  = (state == S_REQ);
    assign inst_addr = inst_req ? addr_r : '0;

    // Primary write register, pulsed for one cycle after an accepted response
    always_ff @(posedge clk) begin
        if (rst) begin
            write_en1      <= 1'b0;
            write_address1 <= '0;
            write_data1    <= '0;
        end else if (resp) begin
            write_en1      <= 1'b1;
            write_address1 <= req_pc;
            write_data1    <= req_pc[2] ? inst_rdata[63:32] : inst_rdata[31:0];
        end else begin
            write_en1      <= 1'b0;
        end
    end

`ifdef FETCH_DUAL_EN
    // Second write slot: only when the fetch started on the even word of the pair
    always_ff @(posedge clk) begin
        if (rst) begin
            write_en2      <= 1'b0;
            write_address2 <= '0;
            write_data2    <= '0;
        end else if (resp) begin
            write_en2      <= !req_pc[2];
            write_address2 <= req_pc + 32'd4;
            write_data2    <= inst_rdata[63:32];
        end else begin
            write_en2      <= 1'b0;
        end
    end
`else
    assign write_en2      = 1'b0;
    assign write_address2 = '0;
    assign write_data2    = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl; expected values follow the FETCH_DUAL_EN build option.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fifo_full;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [63:0] inst_rdata;
    logic        write_en1, write_en2;
    logic [31:0] write_address1, write_address2;
    logic [31:0] write_data1, write_data2;
    logic        fifo_rst;

    int errors = 0;
    int checks = 0;

    inst_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fifo_full      (fifo_full),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .write_en1      (write_en1),
        .write_en2      (write_en2),
        .write_address1 (write_address1),
        .write_address2 (write_address2),
        .write_data1    (write_data1),
        .write_data2    (write_data2),
        .fifo_rst       (fifo_rst)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

`ifdef FETCH_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; fifo_full = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        tick(); tick();
        check("rst_req",   {31'd0, inst_req},  32'd0);
        check("rst_addr",  inst_addr,          32'd0);
        check("rst_we1",   {31'd0, write_en1}, 32'd0);
        check("rst_we2",   {31'd0, write_en2}, 32'd0);
        check("rst_wa1",   write_address1,     32'd0);
        check("rst_wd1",   write_data1,        32'd0);
        check("rst_frst",  {31'd0, fifo_rst},  32'd0);

        // First fetch from reset vector
        rst = 1'b0;
        tick();
        check("t1_req",  {31'd0, inst_req}, 32'd1);
        check("t1_addr", inst_addr, 32'hBFC0_0000);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        check("t1_req_drop", {31'd0, inst_req}, 32'd0);
        tick();
        inst_data_ok = 1'b1; inst_rdata = 64'h2400_0002_2400_0001;
        tick();
        inst_data_ok = 1'b0;
        check("t1_we1", {31'd0, write_en1}, 32'd1);
        check("t1_wa1", write_address1, 32'hBFC0_0000);
        check("t1_wd1", write_data1,    32'h2400_0001);
        check("t1_we2", {31'd0, write_en2}, DUAL ? 32'd1 : 32'd0);
        check("t1_wa2", write_address2, DUAL ? 32'hBFC0_0004 : 32'd0);
        check("t1_wd2", write_data2,    DUAL ? 32'h2400_0002 : 32'd0);
        check("t1_noreq_wr", {31'd0, inst_req}, 32'd0);
        tick();
        check("t1_gap_req", {31'd0, inst_req}, 32'd0);
        tick();
        check("t1_next_req",  {31'd0, inst_req}, 32'd1);
        check("t1_next_addr", inst_addr, DUAL ? 32'hBFC0_0008 : 32'hBFC0_0004);

        // Redirect while the request is stalled on the bus
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0104;
        tick();
        redirect_valid = 1'b0;
        check("t2_frst",   {31'd0, fifo_rst}, 32'd1);
        check("t2_hold0",  inst_addr, DUAL ? 32'hBFC0_0008 : 32'hBFC0_0004);
        tick();
        check("t2_frst_off", {31'd0, fifo_rst}, 32'd0);
        check("t2_hold1",  inst_addr, DUAL ? 32'hBFC0_0008 : 32'hBFC0_0004);
        tick();
        check("t2_hold2",  inst_addr, DUAL ? 32'hBFC0_0008 : 32'hBFC0_0004);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        check("t2_disc_req", {31'd0, inst_req}, 32'd0);
        inst_data_ok = 1'b1; inst_rdata = 64'hFFFF_FFFF_EEEE_EEEE;
        tick();
        inst_data_ok = 1'b0;
        check("t2_disc_we1", {31'd0, write_en1}, 32'd0);
        tick();
        check("t2_new_req",  {31'd0, inst_req}, 32'd1);
        check("t2_new_addr", inst_addr, DUAL ? 32'h8000_0100 : 32'h8000_0104);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 64'h1111_2222_3333_4444;
        tick();
        inst_data_ok = 1'b0;
        check("t2_we1", {31'd0, write_en1}, 32'd1);
        check("t2_wa1", write_address1, 32'h8000_0104);
        check("t2_wd1", write_data1,    32'h1111_2222);
        check("t2_we2", {31'd0, write_en2}, 32'd0);
        tick(); tick();
        check("t2_next_addr", inst_addr, 32'h8000_0108);

        // Backpressure from fifo_full
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        fifo_full = 1'b1;
        inst_data_ok = 1'b1; inst_rdata = 64'h0000_0005_0000_0004;
        tick();
        inst_data_ok = 1'b0;
        check("t3_wa1", write_address1, 32'h8000_0108);
        check("t3_wd1", write_data1,    32'h0000_0004);
        check("t3_we2", {31'd0, write_en2}, DUAL ? 32'd1 : 32'd0);
        check("t3_wd2", write_data2,    DUAL ? 32'h0000_0005 : 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_full_noreq", {31'd0, inst_req}, 32'd0);
        end
        fifo_full = 1'b0;
        tick();
        check("t3_req",  {31'd0, inst_req}, 32'd1);
        check("t3_addr", inst_addr, DUAL ? 32'h8000_0110 : 32'h8000_010C);

        // Redirect during WAIT
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        tick();
        redirect_valid = 1'b0;
        check("t4_frst", {31'd0, fifo_rst}, 32'd1);
        check("t4_we1",  {31'd0, write_en1}, 32'd0);
        tick();
        check("t4_frst_off", {31'd0, fifo_rst}, 32'd0);
        inst_data_ok = 1'b1; inst_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        inst_data_ok = 1'b0;
        check("t4_drop_we1", {31'd0, write_en1}, 32'd0);
        tick();
        check("t4_req",  {31'd0, inst_req}, 32'd1);
        check("t4_addr", inst_addr, 32'h0000_1000);

        // Redirect coincident with data_ok in WAIT
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 64'h0BAD_0001_0BAD_0002;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2004;
        tick();
        inst_data_ok = 1'b0; redirect_valid = 1'b0;
        check("t5_we1",  {31'd0, write_en1}, 32'd0);
        check("t5_frst", {31'd0, fifo_rst}, 32'd1);
        check("t5_req0", {31'd0, inst_req}, 32'd0);
        tick();
        check("t5_req1", {31'd0, inst_req}, 32'd0);
        tick();
        check("t5_req2", {31'd0, inst_req}, 32'd1);
        check("t5_addr", inst_addr, DUAL ? 32'h0000_2000 : 32'h0000_2004);

        // PC wrap at the top of the address space
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        inst_data_ok = 1'b1;
        tick();
        inst_data_ok = 1'b0;
        tick();
        check("t6_addr", inst_addr, DUAL ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 64'hDEAD_0001_CAFE_0002;
        tick();
        inst_data_ok = 1'b0;
        check("t6_wa1", write_address1, 32'hFFFF_FFFC);
        check("t6_wd1", write_data1,    32'hDEAD_0001);
        check("t6_we2", {31'd0, write_en2}, 32'd0);
        tick(); tick();
        check("t6_wrap_addr", inst_addr, 32'h0000_0000);

        // Reset while waiting for data, then a late response
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        rst = 1'b1;
        tick();
        check("t7_req",  {31'd0, inst_req},  32'd0);
        check("t7_addr", inst_addr,          32'd0);
        check("t7_we1",  {31'd0, write_en1}, 32'd0);
        check("t7_wa1",  write_address1,     32'd0);
        check("t7_wd1",  write_data1,        32'd0);
        check("t7_frst", {31'd0, fifo_rst},  32'd0);
        rst = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        inst_data_ok = 1'b0;
        check("t7_late_we1", {31'd0, write_en1}, 32'd0);
        check("t7_req_again", {31'd0, inst_req}, 32'd1);
        check("t7_addr_again", inst_addr, 32'hBFC0_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
